// File: rtl/hdc_kernel_mapper.sv
// -----------------------------------------------------------------------------
// hdc_kernel_mapper
//
// Splits one hypervector operation hvc = op(hva, hvb) of vec_length words into
// per-word jobs and hands them to a bank of NUM_PARALLEL_KERNELS external
// kernel engines. Each kernel gets its next word as soon as it is idle.
// Offsets are handed out in ascending order. When several kernels are free in
// the same cycle, the lowest-indexed free kernel gets the lowest offset.
//
// Optional feature macro: HDC_MAPPER_CYCLE_COUNT_EN
//   defined   -> cycle_count measures the busy time of the current/last request
//                (clears on accept, counts while done=0, saturates)
//   undefined -> cycle_count is tied to 0
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   valid / ready       request handshake (ready only while idle)
//   op, vec_length      operation code, number of words
//   hva, hvb, hvc       operand A / operand B / result base addresses
//   abort               stop issuing new words and drain the in-flight jobs
//   done, aborted       level status of the last request
//   k_valid, k_offset   per-kernel issue pulse and word offset
//   k_op, k_hv*         latched op/addresses, shared by all kernels
//   k_done              per-kernel idle level
//   cycle_count         busy-cycle measurement (see macro above)
// -----------------------------------------------------------------------------
module hdc_kernel_mapper #(
    parameter int HV_ADDRESS_WIDTH     = 20,
    parameter int NUM_PARALLEL_KERNELS = 4,
    parameter int OP_WIDTH             = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            valid,
    output logic                            ready,
    input  logic [OP_WIDTH-1:0]             op,
    input  logic [HV_ADDRESS_WIDTH-1:0]     vec_length,
    input  logic [HV_ADDRESS_WIDTH-1:0]     hva,
    input  logic [HV_ADDRESS_WIDTH-1:0]     hvb,
    input  logic [HV_ADDRESS_WIDTH-1:0]     hvc,
    input  logic                            abort,
    output logic                            done,
    output logic                            aborted,
    output logic [NUM_PARALLEL_KERNELS-1:0] k_valid,
    output logic [HV_ADDRESS_WIDTH-1:0]     k_offset [NUM_PARALLEL_KERNELS],
    output logic [OP_WIDTH-1:0]             k_op,
    output logic [HV_ADDRESS_WIDTH-1:0]     k_hva,
    output logic [HV_ADDRESS_WIDTH-1:0]     k_hvb,
    output logic [HV_ADDRESS_WIDTH-1:0]     k_hvc,
    input  logic [NUM_PARALLEL_KERNELS-1:0] k_done,
    output logic [31:0]                     cycle_count
);

    localparam int W  = HV_ADDRESS_WIDTH;
    localparam int N  = NUM_PARALLEL_KERNELS;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]    state;
    logic [W:0]    len_l;
    logic [W:0]    next_off;
    logic [W:0]    next_off_sum;
    logic [N-1:0]  free;
    logic [N-1:0]  issue;
    logic [CW-1:0] rank [N];
    logic [CW-1:0] issue_cnt;
    logic [W+1:0]  cand [N];

    assign ready = (state == S_IDLE);

    // Rank of each kernel among the free ones (number of free kernels below it).
    always_comb begin
        rank[0] = '0;
        for (int i = 1; i < N; i++) begin
            rank[i] = rank[i-1] + CW'(free[i-1]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_kernel
            // k_valid is high in the cycle right after an issue; the kernel has
            // not dropped k_done yet, so that stale idle level must be ignored.
            assign free[gi]  = k_done[gi] & ~k_valid[gi];
            assign cand[gi]  = {1'b0, next_off} + (W+2)'(rank[gi]);
            assign issue[gi] = (state == S_DISPATCH) && !abort && free[gi]
                               && (cand[gi] < {1'b0, len_l});
        end
    endgenerate

    always_comb begin
        issue_cnt = '0;
        for (int i = 0; i < N; i++) begin
            issue_cnt = issue_cnt + CW'(issue[i]);
        end
    end

    assign next_off_sum = next_off + (W+1)'(issue_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                k_offset[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (issue[i]) begin
                    k_offset[i] <= cand[i][W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            done     <= 1'b1;
            aborted  <= 1'b0;
            k_valid  <= '0;
            k_op     <= '0;
            k_hva    <= '0;
            k_hvb    <= '0;
            k_hvc    <= '0;
            len_l    <= '0;
            next_off <= '0;
        end else begin
            k_valid <= issue;
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        k_op     <= op;
                        k_hva    <= hva;
                        k_hvb    <= hvb;
                        k_hvc    <= hvc;
                        len_l    <= {1'b0, vec_length};
                        next_off <= '0;
                        aborted  <= 1'b0;
                        done     <= 1'b0;
                        state    <= (vec_length == '0) ? S_DONE : S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= S_DRAIN;
                    end else begin
                        next_off <= next_off_sum;
                        if (next_off_sum >= len_l) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Jobs issued last cycle have not yet lowered k_done.
                    if ((&k_done) && !(|k_valid)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HDC_MAPPER_CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
        end else if ((state == S_IDLE) && valid) begin
            cycle_count <= '0;
        end else if (!done && (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_hdc_kernel_mapper.sv
module tb_hdc_kernel_mapper;

    localparam int W  = 20;
    localparam int N  = 4;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          valid = 1'b0;
    logic          ready;
    logic [OW-1:0] op = '0;
    logic [W-1:0]  vec_length = '0;
    logic [W-1:0]  hva = '0;
    logic [W-1:0]  hvb = '0;
    logic [W-1:0]  hvc = '0;
    logic          abort = 1'b0;
    logic          done;
    logic          aborted;
    logic [N-1:0]  k_valid;
    logic [W-1:0]  k_offset [N];
    logic [OW-1:0] k_op;
    logic [W-1:0]  k_hva;
    logic [W-1:0]  k_hvb;
    logic [W-1:0]  k_hvc;
    logic [N-1:0]  k_done;
    logic [31:0]   cycle_count;

    int n_vec  = 0;
    int n_fail = 0;

    hdc_kernel_mapper #(
        .HV_ADDRESS_WIDTH    (W),
        .NUM_PARALLEL_KERNELS(N),
        .OP_WIDTH            (OW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid      (valid),
        .ready      (ready),
        .op         (op),
        .vec_length (vec_length),
        .hva        (hva),
        .hvb        (hvb),
        .hvc        (hvc),
        .abort      (abort),
        .done       (done),
        .aborted    (aborted),
        .k_valid    (k_valid),
        .k_offset   (k_offset),
        .k_op       (k_op),
        .k_hva      (k_hva),
        .k_hvb      (k_hvb),
        .k_hvc      (k_hvc),
        .k_done     (k_done),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- kernel engines: busy for busy_cfg[i] cycles ----------------
    int busy_cfg [N];
    int kcnt [N];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                kcnt[i] = 0;
                k_done[i] <= 1'b1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (k_valid[i]) begin
                    kcnt[i] = busy_cfg[i];
                    k_done[i] <= 1'b0;
                end else if (kcnt[i] > 0) begin
                    kcnt[i] = kcnt[i] - 1;
                    if (kcnt[i] == 0) k_done[i] <= 1'b1;
                end
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_DISP, M_DRAIN, M_DONE} mph_t;
    mph_t          m_ph;
    int            m_len, m_next;
    bit            m_done, m_abt;
    logic [N-1:0]  m_kv, m_prev;
    logic [W-1:0]  m_off [N];
    logic [OW-1:0] m_op;
    logic [W-1:0]  m_hva, m_hvb, m_hvc;
    longint        m_cc;
    int            m_fq [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph = M_IDLE; m_len = 0; m_next = 0; m_done = 1'b1; m_abt = 1'b0;
            m_kv = '0; m_op = '0; m_hva = '0; m_hvb = '0; m_hvc = '0; m_cc = 0;
            for (int i = 0; i < N; i++) m_off[i] = '0;
        end else begin
            m_prev = m_kv;
            m_kv   = '0;
`ifdef HDC_MAPPER_CYCLE_COUNT_EN
            if (m_ph == M_IDLE && valid) m_cc = 0;
            else if (!m_done && m_cc < 64'hFFFF_FFFF) m_cc = m_cc + 1;
`endif
            case (m_ph)
                M_IDLE: if (valid) begin
                    m_op = op; m_hva = hva; m_hvb = hvb; m_hvc = hvc;
                    m_len = int'(vec_length); m_next = 0; m_abt = 1'b0; m_done = 1'b0;
                    if (m_len == 0) m_ph = M_DONE; else m_ph = M_DISP;
                end
                M_DISP: begin
                    if (abort) begin
                        m_abt = 1'b1;
                        m_ph  = M_DRAIN;
                    end else begin
                        m_fq.delete();
                        for (int i = 0; i < N; i++)
                            if (k_done[i] && !m_prev[i]) m_fq.push_back(i);
                        foreach (m_fq[j]) begin
                            if (m_next < m_len) begin
                                m_kv[m_fq[j]]  = 1'b1;
                                m_off[m_fq[j]] = W'(m_next);
                                m_next++;
                            end
                        end
                        if (m_next >= m_len) m_ph = M_DRAIN;
                    end
                end
                M_DRAIN: if ((&k_done) && m_prev == '0) m_ph = M_DONE;
                M_DONE: begin
                    m_done = 1'b1;
                    m_ph   = M_IDLE;
                end
                default: m_ph = M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare + offset scoreboard ----------------
    int seen [64];
    int kpulses [N];
    int koff_last [N];
    int issued_total;
    int oor;

    always @(negedge clk) begin
        chk("ready", 64'(ready), 64'(m_ph == M_IDLE));
        chk("done", 64'(done), 64'(m_done));
        chk("aborted", 64'(aborted), 64'(m_abt));
        chk("k_valid", 64'(k_valid), 64'(m_kv));
        for (int i = 0; i < N; i++) chk($sformatf("k_offset%0d", i), 64'(k_offset[i]), 64'(m_off[i]));
        chk("k_op", 64'(k_op), 64'(m_op));
        chk("k_hva", 64'(k_hva), 64'(m_hva));
        chk("k_hvb", 64'(k_hvb), 64'(m_hvb));
        chk("k_hvc", 64'(k_hvc), 64'(m_hvc));
`ifdef HDC_MAPPER_CYCLE_COUNT_EN
        chk("cycle_count", 64'(cycle_count), 64'(m_cc));
`else
        chk("cycle_count", 64'(cycle_count), 64'd0);
`endif
        for (int i = 0; i < N; i++) begin
            if (k_valid[i] === 1'b1) begin
                int idx;
                idx = int'(k_offset[i]);
                issued_total++;
                kpulses[i]++;
                koff_last[i] = idx;
                if (idx < 64) seen[idx]++;
                else oor++;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic clear_sb();
        for (int i = 0; i < 64; i++) seen[i] = 0;
        for (int i = 0; i < N; i++) begin
            kpulses[i] = 0;
            koff_last[i] = -1;
        end
        issued_total = 0;
        oor = 0;
    endtask

    task automatic set_busy(input int b0, input int b1, input int b2, input int b3);
        busy_cfg[0] = b0; busy_cfg[1] = b1; busy_cfg[2] = b2; busy_cfg[3] = b3;
    endtask

    // Presents one request for one clock edge; returns just after the accept edge.
    task automatic start_op(input int len, input logic [OW-1:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] c);
        clear_sb();
        op = o; hva = a; hvb = b; hvc = c; vec_length = W'(len);
        valid = 1'b1;
        @(negedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk); #1;
            cyc++;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    // Every offset below len exactly once (exact) or at most once (aborted).
    function automatic int bad_offsets(input int len, input bit exact);
        int bad;
        bad = oor;
        for (int o = 0; o < 64; o++) begin
            if (o < len) begin
                if (exact ? (seen[o] != 1) : (seen[o] > 1)) bad++;
            end else if (seen[o] != 0) begin
                bad++;
            end
        end
        return bad;
    endfunction

    int cyc;

    initial begin
        set_busy(3, 3, 3, 3);
        clear_sb();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        chk("rst_done", 64'(done), 64'd1);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_aborted", 64'(aborted), 64'd0);
        chk("rst_k_valid", 64'(k_valid), 64'd0);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
        @(negedge clk); #1;

        // 10 words on 4 equal kernels
        start_op(10, 2'd1, W'(20'h100), W'(20'h200), W'(20'h300));
        @(negedge clk); #1;
        chk("len10_first_kvalid", 64'(k_valid), 64'hF);
        chk("len10_first_off3", 64'(k_offset[3]), 64'd3);
        wait_done(500, cyc);
        chk("len10_offsets", 64'(bad_offsets(10, 1'b1)), 64'd0);
        chk("len10_issued", 64'(issued_total), 64'd10);
        chk("len10_aborted", 64'(aborted), 64'd0);

        // 3 words: k3 stays quiet
        start_op(3, 2'd2, W'(20'h11), W'(20'h22), W'(20'h33));
        wait_done(500, cyc);
        chk("len3_k3_pulses", 64'(kpulses[3]), 64'd0);
        chk("len3_offsets", 64'(bad_offsets(3, 1'b1)), 64'd0);

        // zero length
        start_op(0, 2'd3, W'(20'h5), W'(20'h6), W'(20'h7));
        chk("len0_done_low", 64'(done), 64'd0);
        @(negedge clk); #1;
        chk("len0_done_high", 64'(done), 64'd1);
        chk("len0_issued", 64'(issued_total), 64'd0);

        // slow kernel 1
        set_busy(1, 10, 1, 1);
        start_op(12, 2'd0, W'(20'hA), W'(20'hB), W'(20'hC));
        wait_done(500, cyc);
        chk("slow_k1_pulses", 64'(kpulses[1]), 64'd1);
        chk("slow_k1_offset", 64'(koff_last[1]), 64'd1);
        chk("slow_offsets", 64'(bad_offsets(12, 1'b1)), 64'd0);

        // abort after 5 offsets issued
        set_busy(3, 3, 3, 3);
        start_op(20, 2'd1, W'(20'h1000), W'(20'h2000), W'(20'h3000));
        cyc = 0;
        while (issued_total < 5 && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        wait_done(500, cyc);
        chk("abort_issued", 64'(issued_total), 64'd8);
        chk("abort_flag", 64'(aborted), 64'd1);
        chk("abort_offsets", 64'(bad_offsets(8, 1'b1)), 64'd0);
        start_op(2, 2'd0, W'(20'h1), W'(20'h2), W'(20'h3));
        chk("abort_cleared", 64'(aborted), 64'd0);
        wait_done(500, cyc);

        // valid while busy, then reset mid-dispatch
        start_op(20, 2'd2, W'(20'hABC), W'(20'hDEF), W'(20'h123));
        op = 2'd3; hva = W'(20'h777); vec_length = W'(5);
        valid = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
        valid = 1'b0;
        chk("busy_valid_hva", 64'(k_hva), 64'h00ABC);
        chk("busy_valid_ready", 64'(ready), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_done", 64'(done), 64'd1);
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_k_valid", 64'(k_valid), 64'd0);
        chk("midrst_k_hva", 64'(k_hva), 64'd0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk); #1;

        // busy-cycle measurement
        set_busy(2, 2, 2, 2);
        start_op(8, 2'd1, W'(20'h40), W'(20'h50), W'(20'h60));
        wait_done(500, cyc);
        chk("len8_offsets", 64'(bad_offsets(8, 1'b1)), 64'd0);
`ifdef HDC_MAPPER_CYCLE_COUNT_EN
        chk("cycle_count_measured", 64'(cycle_count), 64'(cyc));
`else
        chk("cycle_count_tied", 64'(cycle_count), 64'd0);
`endif

        // randomized requests
        for (int t = 0; t < 14; t++) begin
            int len, dly;
            bit do_abort;
            set_busy(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                     int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
            len = int'($urandom_range(0, 24));
            do_abort = ($urandom_range(0, 3) == 0);
            dly = int'($urandom_range(0, 6));
            start_op(len, OW'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom));
            if (do_abort) begin
                repeat (dly) begin @(negedge clk); #1; end
                if (!done) begin
                    abort = 1'b1;
                    @(negedge clk); #1;
                    abort = 1'b0;
                end
            end
            wait_done(800, cyc);
            if (aborted) chk($sformatf("rand%0d_offsets", t), 64'(bad_offsets(len, 1'b0)), 64'd0);
            else         chk($sformatf("rand%0d_offsets", t), 64'(bad_offsets(len, 1'b1)), 64'd0);
            @(negedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
